uart_rx_cfg: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8N1 receiver. It adds an internal baud/oversample divider, configurable data width, parity and stop bits, and 3-sample majority voting. It reports per-character parity and framing errors, buffers received characters in a FIFO with a valid/ready output, and flags overrun. It sits between the board RX pin and the ChaCha20 key/nonce/plaintext loader, and runs on the system clock.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_rx_cfg.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states, error flag positions.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int ERR_FRAME  = 0;
    localparam int ERR_PARITY = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO holding received characters with their error flags.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & valid;
    // A push into a full FIFO only fits when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: tick divider, 3-sample majority vote, parity/stop
// checking and a show-ahead output FIFO with overrun reporting.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_BITS-1:0]          m_data,
    output logic [1:0]                    m_err,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int FW = DATA_BITS + 2;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_S0    = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_S1    = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_S2    = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rxd_m, rxd_s;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    rx_state_e            state;
    logic [PW-1:0]        phase;
    logic [2:0]           samp;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err, frame_err, armed;
    logic                 vote, bit_end, last_stop, ferr_now, push;
    logic                 fifo_full;
    logic [FW-1:0]        head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    assign vote      = maj3(samp);
    assign bit_end   = tick & (state != ST_IDLE) & (phase == PH_LAST);
    assign last_stop = (STOP_BITS == 1) || stop_cnt;
    assign ferr_now  = frame_err | ~vote;
    assign push      = bit_end & (state == ST_STOP) & last_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= '0;
            samp      <= '1;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            armed     <= 1'b1;
        end else if (tick) begin
            if (state == ST_IDLE) begin
                phase <= '0;
                // The start tick itself is phase 0 of the start bit.
                if (rxd_s) begin
                    armed <= 1'b1;
                end else if (armed) begin
                    state <= ST_START;
                    phase <= PW'(1);
                end
            end else begin
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                if (phase == PH_S0) samp[0] <= rxd_s;
                if (phase == PH_S1) samp[1] <= rxd_s;
                if (phase == PH_S2) samp[2] <= rxd_s;
                if (phase == PH_LAST) begin
                    unique case (state)
                        ST_START: begin
                            if (vote) begin
                                state <= ST_IDLE;
                            end else begin
                                state     <= ST_DATA;
                                bit_cnt   <= '0;
                                par_err   <= 1'b0;
                                frame_err <= 1'b0;
                            end
                        end
                        ST_DATA: begin
                            shreg[bit_cnt] <= vote;
                            if (bit_cnt == BIT_LAST) begin
                                state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                                stop_cnt <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        ST_PARITY: begin
                            par_err <= (^{shreg, vote}) ^ (PARITY == PAR_ODD);
                            state   <= ST_STOP;
                        end
                        ST_STOP: begin
                            frame_err <= ferr_now;
                            if (last_stop) begin
                                state <= ST_IDLE;
                                // Stay disarmed across a break until the line goes high.
                                armed <= ~ferr_now;
                            end else begin
                                stop_cnt <= 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

    uart_rx_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({par_err, ferr_now, shreg}),
        .pop   (m_ready),
        .rdata (head),
        .valid (m_valid),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign m_data            = head[DATA_BITS-1:0];
    assign m_err[ERR_FRAME]  = head[DATA_BITS];
    assign m_err[ERR_PARITY] = head[DATA_BITS+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 1'b0;
        else        overrun <= push & fifo_full & ~(m_valid & m_ready);
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations driven one at a time.
module tb_uart_rx_cfg;
    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic [2:0] rst_n, rxd, m_ready;

    logic       v0, v1, v2, ov0, ov1, ov2, b0, b1, b2;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [1:0] e0, e1, e2;
    logic [2:0] c0, c1, c2;

    int checks = 0;
    int errors = 0;
    int q0[$], q1[$], q2[$];
    int ovc0 = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .rxd(rxd[0]), .m_valid(v0), .m_ready(m_ready[0]),
        .m_data(d0), .m_err(e0), .overrun(ov0), .busy(b0), .fifo_count(c0));

    uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .rxd(rxd[1]), .m_valid(v1), .m_ready(m_ready[1]),
        .m_data(d1), .m_err(e1), .overrun(ov1), .busy(b1), .fifo_count(c1));

    uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .rxd(rxd[2]), .m_valid(v2), .m_ready(m_ready[2]),
        .m_data(d2), .m_err(e2), .overrun(ov2), .busy(b2), .fifo_count(c2));

    // Accepted beats are logged as err*512 + data.
    always @(posedge clk) begin
        if (v0 && m_ready[0]) q0.push_back(int'(e0) * 512 + int'(d0));
        if (v1 && m_ready[1]) q1.push_back(int'(e1) * 512 + int'(d1));
        if (v2 && m_ready[2]) q2.push_back(int'(e2) * 512 + int'(d2));
        if (ov0) ovc0++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int u, input int i);
        case (u)
            0:       return (i < q0.size()) ? q0[i] : -1;
            1:       return (i < q1.size()) ? q1[i] : -1;
            default: return (i < q2.size()) ? q2[i] : -1;
        endcase
    endfunction

    task automatic send(input int u, input int n, input logic [15:0] v, input int gap);
        for (int i = 0; i < n; i++) begin
            rxd[u] = v[i];
            repeat (BIT) @(negedge clk);
        end
        if (gap > 0) begin
            rxd[u] = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        int base, ovb, bh;
        logic [15:0] v;

        rst_n = '0; rxd = '1; m_ready = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(v0), 0);
        chk("rst_data", 32'(d0), 0);
        chk("rst_err", 32'(e0), 0);
        chk("rst_overrun", 32'(ov0), 0);
        chk("rst_busy", 32'(b0), 0);
        chk("rst_count", 32'(c0), 0);
        rst_n = '1;
        repeat (BIT) @(negedge clk);

        // 8N1, two characters straight through
        m_ready[0] = 1'b1;
        base = q0.size(); ovb = ovc0;
        send(0, 10, {6'b0, 1'b1, 8'hA5, 1'b0}, BIT);
        send(0, 10, {6'b0, 1'b1, 8'h3C, 1'b0}, BIT);
        chk("8n1_beats", 32'(q0.size() - base), 2);
        chk("8n1_first", 32'(qat(0, base)), 'hA5);
        chk("8n1_second", 32'(qat(0, base + 1)), 'h3C);
        chk("8n1_overrun", 32'(ovc0 - ovb), 0);

        // even parity: 0x07 needs parity bit 1
        m_ready[1] = 1'b1;
        base = q1.size();
        send(1, 11, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, BIT);
        send(1, 11, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, BIT);
        chk("par_beats", 32'(q1.size() - base), 2);
        chk("par_bad", 32'(qat(1, base)), 2 * 512 + 'h07);
        chk("par_good", 32'(qat(1, base + 1)), 'h07);

        // framing error followed by a held break
        base = q0.size();
        send(0, 10, {6'b0, 1'b0, 8'h55, 1'b0}, 0);
        repeat (BIT / 2) @(negedge clk);
        bh = 0;
        for (int i = 0; i < 5 * BIT / 2; i++) begin
            @(negedge clk);
            if (b0) bh++;
        end
        chk("brk_busy_cycles", 32'(bh), 0);
        chk("brk_beats", 32'(q0.size() - base), 1);
        chk("brk_char", 32'(qat(0, base)), 1 * 512 + 'h55);
        rxd[0] = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("brk_beats_after", 32'(q0.size() - base), 1);
        chk("brk_count", 32'(c0), 0);

        // 4-tick start glitch
        base = q0.size();
        rxd[0] = 1'b0;
        repeat (16) @(negedge clk);
        chk("glitch_busy_hi", 32'(b0), 1);
        rxd[0] = 1'b1;
        repeat (BIT + 8) @(negedge clk);
        chk("glitch_busy_lo", 32'(b0), 0);
        chk("glitch_count", 32'(c0), 0);
        chk("glitch_beats", 32'(q0.size() - base), 0);

        // fill the FIFO and overflow it
        m_ready[0] = 1'b0;
        base = q0.size(); ovb = ovc0;
        for (int k = 0; k < 4; k++) begin
            v = {6'b0, 1'b1, 8'h11 + 8'(k), 1'b0};
            send(0, 10, v, BIT / 2);
        end
        chk("full_count", 32'(c0), 4);
        chk("full_valid", 32'(v0), 1);
        chk("full_head", 32'(d0), 'h11);
        chk("full_no_ovr", 32'(ovc0 - ovb), 0);
        send(0, 10, {6'b0, 1'b1, 8'h15, 1'b0}, BIT / 2);
        chk("ovr_pulses", 32'(ovc0 - ovb), 1);
        chk("ovr_count", 32'(c0), 4);
        m_ready[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("drain_beats", 32'(q0.size() - base), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("drain_%0d", k), 32'(qat(0, base + k)), 'h11 + k);
        chk("drain_count", 32'(c0), 0);
        chk("drain_valid", 32'(v0), 0);

        // 7O2: reset mid data bit 3 with one character already buffered
        send(2, 11, {5'b0, 2'b11, 1'b1, 7'h41, 1'b0}, BIT / 2);
        chk("7o2_buffered", 32'(c2), 1);
        chk("7o2_head", 32'(d2), 'h41);
        send(2, 4, 16'b0010, 0);
        rxd[2] = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        chk("mid_busy", 32'(b2), 1);
        rst_n[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_valid", 32'(v2), 0);
        chk("mrst_data", 32'(d2), 0);
        chk("mrst_err", 32'(e2), 0);
        chk("mrst_overrun", 32'(ov2), 0);
        chk("mrst_busy", 32'(b2), 0);
        chk("mrst_count", 32'(c2), 0);
        rxd[2] = 1'b1;
        rst_n[2] = 1'b1;
        m_ready[2] = 1'b1;
        repeat (BIT) @(negedge clk);
        base = q2.size();
        send(2, 11, {5'b0, 2'b11, 1'b1, 7'h41, 1'b0}, BIT);
        chk("post_rst_beats", 32'(q2.size() - base), 1);
        chk("post_rst_char", 32'(qat(2, base)), 'h41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
